// File: rtl/bit_manip_pkg.sv
// Shared definitions for the bit-manipulation unit: operation select encodings.
package bit_manip_pkg;

  localparam logic [1:0] OP_ROT    = 2'b00;
  localparam logic [1:0] OP_MASK   = 2'b01;
  localparam logic [1:0] OP_PACK   = 2'b10;
  localparam logic [1:0] OP_UNPACK = 2'b11;

endpackage

// File: rtl/bit_rotl.sv
// Combinational left barrel rotator: M stages, stage k rotates by 2^k when shift_amt[k] is set.
module bit_rotl #(
  parameter int unsigned N = 16,
  parameter int unsigned M = $clog2(N)
) (
  input  logic [N-1:0] data,
  input  logic [M-1:0] shift_amt,
  output logic [N-1:0] result
);

  logic [N-1:0] stage [0:M];

  assign stage[0] = data;

  for (genvar k = 0; k < M; k++) begin : g_stage
    localparam int unsigned Sh = 1 << k;
    assign stage[k+1] = shift_amt[k] ? {stage[k][N-1-Sh:0], stage[k][N-1:N-Sh]} : stage[k];
  end

  assign result = stage[M];

endmodule

// File: rtl/bit_manip_unit.sv
// Single-cycle bit-manipulation datapath (rotate, mask, pack, unpack) with registered outputs.
module bit_manip_unit
  import bit_manip_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned M = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] data,
  input  logic [N-1:0] data2,
  input  logic [1:0]   op_code,
  input  logic [M-1:0] shift_amt,
  input  logic [N-1:0] mask_val,
  output logic [N-1:0] out,
  output logic [N-1:0] out2
);

  localparam int unsigned Half = N / 2;

  logic [N-1:0] rot_res;
  logic [N-1:0] out_d;
  logic [N-1:0] out2_d;

  bit_rotl #(
    .N(N),
    .M(M)
  ) u_rotl (
    .data      (data),
    .shift_amt (shift_amt),
    .result    (rot_res)
  );

  // out2 defaults to zero so it can never carry a stale UNPACK result.
  always_comb begin
    out_d  = '0;
    out2_d = '0;
    unique case (op_code)
      OP_ROT:    out_d = rot_res;
      OP_MASK:   out_d = data & mask_val;
      OP_PACK:   out_d = {data[Half-1:0], data2[Half-1:0]};
      OP_UNPACK: begin
        out_d  = {{Half{1'b0}}, data[N-1:Half]};
        out2_d = {{Half{1'b0}}, data[Half-1:0]};
      end
      default: begin
        out_d  = '0;
        out2_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out  <= '0;
      out2 <= '0;
    end else begin
      out  <= out_d;
      out2 <= out2_d;
    end
  end

endmodule

// File: tb/tb_bit_manip_unit.sv
// Self-checking bench: N = 8, 16 and 32 instances share stimulus, checked against a bit-level model.
module tb_bit_manip_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  op_code;
  logic [31:0] data;
  logic [31:0] data2;
  logic [31:0] mask_val;
  logic [4:0]  shift_amt;

  logic [7:0]  o8,  p8;
  logic [15:0] o16, p16;
  logic [31:0] o32, p32;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] e_o  [3];
  logic [31:0] e_o2 [3];
  int          widths [3] = '{8, 16, 32};

  always #5 clk = ~clk;

  bit_manip_unit #(.N(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .data      (data[7:0]),
    .data2     (data2[7:0]),
    .op_code   (op_code),
    .shift_amt (shift_amt[2:0]),
    .mask_val  (mask_val[7:0]),
    .out       (o8),
    .out2      (p8)
  );

  bit_manip_unit #(.N(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .data      (data[15:0]),
    .data2     (data2[15:0]),
    .op_code   (op_code),
    .shift_amt (shift_amt[3:0]),
    .mask_val  (mask_val[15:0]),
    .out       (o16),
    .out2      (p16)
  );

  bit_manip_unit #(.N(32)) dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .data      (data),
    .data2     (data2),
    .op_code   (op_code),
    .shift_amt (shift_amt),
    .mask_val  (mask_val),
    .out       (o32),
    .out2      (p32)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: each result bit placed individually from the operation's definition.
  function automatic void model(input int n, input logic [1:0] op, input logic [31:0] d,
                                input logic [31:0] d2, input logic [31:0] m, input int s,
                                output logic [31:0] o, output logic [31:0] o2);
    int h = n / 2;
    o  = '0;
    o2 = '0;
    case (op)
      2'd0: for (int i = 0; i < n; i++) o[(i + s) % n] = d[i];
      2'd1: for (int i = 0; i < n; i++) o[i] = d[i] & m[i];
      2'd2: for (int i = 0; i < h; i++) begin
        o[i]     = d2[i];
        o[i + h] = d[i];
      end
      default: for (int i = 0; i < h; i++) begin
        o[i]  = d[i + h];
        o2[i] = d[i];
      end
    endcase
  endfunction

  function automatic logic [31:0] dut_out(input int k);
    case (k)
      0:       return {24'b0, o8};
      1:       return {16'b0, o16};
      default: return o32;
    endcase
  endfunction

  function automatic logic [31:0] dut_out2(input int k);
    case (k)
      0:       return {24'b0, p8};
      1:       return {16'b0, p16};
      default: return p32;
    endcase
  endfunction

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s out N=%0d", tag, widths[k]), dut_out(k), e_o[k]);
      check($sformatf("%s out2 N=%0d", tag, widths[k]), dut_out2(k), e_o2[k]);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] exp_o, input logic [15:0] exp_o2);
    check({tag, " out"}, {16'b0, o16}, {16'b0, exp_o});
    check({tag, " out2"}, {16'b0, p16}, {16'b0, exp_o2});
  endtask

  // Drive one operation; outputs must hold until the edge, then show the model's result.
  task automatic run_op(input logic [1:0] op, input logic [31:0] d, input logic [31:0] d2,
                        input logic [4:0] s, input logic [31:0] m);
    @(negedge clk);
    op_code   = op;
    data      = d;
    data2     = d2;
    shift_amt = s;
    mask_val  = m;
    #1 check_all("hold");
    for (int k = 0; k < 3; k++)
      model(widths[k], op, d, d2, m, int'(s) % widths[k], e_o[k], e_o2[k]);
    @(posedge clk);
    #1 check_all("result");
  endtask

  task automatic clear_expect();
    for (int k = 0; k < 3; k++) begin
      e_o[k]  = '0;
      e_o2[k] = '0;
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    op_code   = 2'd0;
    data      = '0;
    data2     = '0;
    mask_val  = '0;
    shift_amt = '0;
    clear_expect();
    #1 rst_n = 1'b0;
    #1 check_all("reset");
    @(posedge clk);
    #1 check_all("reset held");
    #2 rst_n = 1'b1;

    // Rotate
    run_op(2'd0, 32'h0000_A5A5, 32'h1111_1111, 5'd0, 32'h0);
    check16("rot s0", 16'hA5A5, 16'h0);
    run_op(2'd0, 32'h0000_A5A5, 32'h2222_2222, 5'd15, 32'hFFFF_FFFF);
    check16("rot s15", 16'hD2D2, 16'h0);
    run_op(2'd0, 32'h0000_FFFF, 32'h0, 5'd4, 32'h0);
    check16("rot ones", 16'hFFFF, 16'h0);
    run_op(2'd0, 32'h0000_0001, 32'h0, 5'd15, 32'h0);
    check16("rot msb", 16'h8000, 16'h0);

    // Mask
    run_op(2'd1, 32'h0000_A5A5, 32'hFFFF_FFFF, 5'd7, 32'h0000_0000);
    check16("mask zero", 16'h0000, 16'h0);
    run_op(2'd1, 32'h0000_A5A5, 32'h0, 5'd3, 32'h0000_FFFF);
    check16("mask ones", 16'hA5A5, 16'h0);
    run_op(2'd1, 32'h0000_A5A5, 32'h0, 5'd1, 32'h0000_0FF0);
    check16("mask mid", 16'h05A0, 16'h0);

    // Pack
    run_op(2'd2, 32'h0000_1234, 32'h0000_ABCD, 5'd9, 32'hFFFF_FFFF);
    check16("pack a", 16'h34CD, 16'h0);
    run_op(2'd2, 32'h0000_0F0F, 32'h0000_F0F0, 5'd0, 32'h0);
    check16("pack b", 16'h0FF0, 16'h0);

    // Unpack then back-to-back op changes
    run_op(2'd3, 32'h0000_DEAD, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFF);
    check16("unpack", 16'h00DE, 16'h00AD);
    run_op(2'd1, 32'h0000_DEAD, 32'h0, 5'd0, 32'h0000_FF00);
    check16("mask after unpack", 16'hDE00, 16'h0);
    run_op(2'd3, 32'h0000_BEEF, 32'h0, 5'd0, 32'h0);
    check16("unpack b2b", 16'h00BE, 16'h00EF);
    run_op(2'd2, 32'h0000_1234, 32'h0000_5678, 5'd0, 32'h0);
    check16("pack after unpack", 16'h3478, 16'h0);
    run_op(2'd0, 32'h0000_1234, 32'h0, 5'd4, 32'h0);
    check16("rot b2b", 16'h2341, 16'h0);

    // Asynchronous reset mid-operation, released between edges
    run_op(2'd3, 32'h0000_CAFE, 32'h0, 5'd0, 32'h0);
    #2 rst_n = 1'b0;
    clear_expect();
    #1 check_all("async reset");
    @(posedge clk);
    #1 check_all("reset held mid-op");
    #2 rst_n = 1'b1;
    run_op(2'd1, 32'h0000_A5A5, 32'h0, 5'd0, 32'h0000_FFFF);
    check16("first after reset", 16'hA5A5, 16'h0);

    // Random
    for (int i = 0; i < 600; i++) begin
      run_op(2'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom_range(0, 31)), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_manip_unit.md
# bit_manip_unit

Single-cycle bit-manipulation datapath with registered outputs. Performs one of four operations, selected by a 2-bit op code: rotate-left, mask, pack and unpack. Sits beside the ALU as a utility unit. The operand word width is parameterized.

## Interface
Parameters:
- `N`, default 16: operand/result width. Must be even and a power of two, ≥ 4.
- `M`, default `$clog2(N)`: width of the shift amount. Callers do not override it independently of `N`.

Ports:
- `clk`, input, 1: single clock; rising-edge active.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `data`, input, N: primary operand.
- `data2`, input, N: secondary operand; used by pack only.
- `op_code`, input, 2: operation select.
- `shift_amt`, input, M: rotate amount, 0..N-1; used by rotate only.
- `mask_val`, input, N: AND mask; used by mask only.
- `out`, output, N: primary result (registered).
- `out2`, output, N: secondary result (registered).

## Operation
HALF = N/2. Results are computed combinationally, then registered.
- `2'b00` ROTATE: `out` = `data` rotated left by `shift_amt`, i.e. `(data << s) | (data >> (N-s))`. `shift_amt` = 0 gives `data` unchanged. `out2` = 0.
- `2'b01` MASK: `out` = `data & mask_val`; `out2` = 0.
- `2'b10` PACK: `out` = `{data[HALF-1:0], data2[HALF-1:0]}`; `out2` = 0.
- `2'b11` UNPACK: `out` = `data[N-1:HALF]` zero-extended to N; `out2` = `data[HALF-1:0]` zero-extended to N.
- Inputs not used by the selected op must not affect the result.
- `out2` is nonzero only for UNPACK.
- No overflow or status flags. All arithmetic is pure bit selection and wiring; no carries.

## Timing
- Reset (`rst_n` low, asynchronous): `out` and `out2` go to 0 immediately and stay 0 while reset is held.
- Latency 1 cycle: inputs are sampled on the rising `clk` edge, and the result appears on `out`/`out2` after that edge.
- Throughput is one operation per cycle. There is no handshake and no stall.
- Outputs hold their value until the next rising edge.
- Changing `op_code` between consecutive cycles takes effect on the very next edge. No stale `out2`: for example, UNPACK followed by MASK gives `out2` = 0 on the second result.
- Reset deasserting between edges: the first valid result appears at the first rising edge after deassertion.
- The combinational path from inputs to the register D input must close within one cycle. The rotator is a log2(N)-stage barrel structure, not a serial shifter.

## Structure
- Package `bit_manip_pkg`: op-code localparams `OP_ROT` = 2'b00, `OP_MASK` = 2'b01, `OP_PACK` = 2'b10, `OP_UNPACK` = 2'b11.
- Sub-module `bit_rotl` (parameters `N`, `M`): combinational left barrel rotator with M stages; stage k rotates by 2^k when `shift_amt[k]` is set.
- Top level contains: the rotator, mask/pack/unpack wiring, the op-code mux, and the output registers with async reset.

## Test plan
- Reset: assert `rst_n` = 0 mid-operation -> `out` = 0 and `out2` = 0 asynchronously. Release, apply MASK `data` = A5A5, `mask_val` = FFFF -> `out` = A5A5 after one edge.
- Rotate (N = 16): `data` = A5A5, s = 0 -> A5A5. s = 15 -> D2D2. `data` = FFFF, s = 4 -> FFFF. `data` = 0001, s = 15 -> 8000. `out2` = 0 in every case.
- Mask: `data` = A5A5 with `mask_val` = 0000 -> 0000. With `mask_val` = FFFF -> A5A5. With `mask_val` = 0FF0 -> 05A0.
- Pack: 1234/ABCD -> `out` = 34CD, `out2` = 0. 0F0F/F0F0 -> `out` = 0FF0.
- Unpack: `data` = DEAD -> `out` = 00DE, `out2` = 00AD. Next cycle MASK -> `out2` returns to 0. Check that one-cycle latency holds across back-to-back op changes.
- Random: 500+ cycles of random `op_code`, `data`, `data2`, `shift_amt` and `mask_val`, compared against a one-cycle-delayed reference model. Also run at N = 8 and N = 32.
